// File: rtl/seq_shift_unit_if.sv
// Request/result handshake bundle for the iterative shift engine.
// The slave side is the shifter; the master side issues requests and consumes results.
interface seq_shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMTW-1:0]  in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle LSR/LSL/ASR/ASL engine: one bit position per clock,
// valid/ready on request and result, at most one request in flight.
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_shift_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic signed [WIDTH-1:0] shreg;
  logic [AMTW-1:0]         cnt;
  logic [1:0]              op;
  logic                    accept;

  // Single-bit step; op 01 and 11 both shift left with zero fill.
  function automatic logic signed [WIDTH-1:0] shift_one(
    input logic signed [WIDTH-1:0] v,
    input logic [1:0]              o
  );
    case (o)
      2'b00:   shift_one = {1'b0, v[WIDTH-1:1]};
      2'b10:   shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
      default: shift_one = {v[WIDTH-2:0], 1'b0};
    endcase
  endfunction

  assign accept = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = (bus.in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == AMTW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured only on the accept edge; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      op    <= '0;
    end else if (accept) begin
      shreg <= bus.in_data;
      cnt   <= bus.in_amt;
      op    <= bus.in_op;
    end else if (state == SHIFT) begin
      shreg <= shift_one(shreg, op);
      cnt   <= cnt - AMTW'(1);
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE:    bus.in_ready = 1'b1;
      SHIFT:   bus.busy     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready = 1'b1;
    endcase
  end

  assign bus.out_data = shreg;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit with a result scoreboard and latency tracking.
module tb_seq_shift_unit;
  localparam int WIDTH = 8;
  localparam int AMTW  = 3;
  localparam logic [1:0] LSR = 2'b00, LSL = 2'b01, ASR = 2'b10, ASL = 2'b11;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_shift_unit_if #(.WIDTH(WIDTH), .AMTW(AMTW)) bus ();

  seq_shift_unit #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t popped;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   acc_cnt = 0;
  int   hs_cnt = 0;
  int   hs_cyc = 0;
  bit   seen = 0;
  bit   b2b = 0;
  bit   b2b_armed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result side: latency on first sight of out_valid, data on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          fail("unexpected_result");
        end else begin
          if (!seen) begin
            check("latency", 32'(cyc - acc_cyc + 1), 32'(sb[0].lat));
            seen = 1;
          end
          if (bus.out_ready) begin
            popped = sb.pop_front();
            check("out_data", 32'(bus.out_data), 32'(popped.data));
            seen   = 0;
            hs_cyc = cyc + 1;
            hs_cnt++;
            if (b2b) b2b_armed = 1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (b2b && b2b_armed) check("b2b_accept_edge", 32'(cyc + 1), 32'(hs_cyc + 1));
        acc_cyc = cyc + 1;
        acc_cnt++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o,
                      input logic [7:0] want, input bit keep);
    int   start;
    exp_t e;
    start  = acc_cnt;
    e.data = want;
    e.lat  = int'(a) + 1;
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_op    = o;
    for (int i = 0; i < 50 && acc_cnt == start; i++) @(posedge clk);
    if (acc_cnt == start) fail("accept_timeout");
    #1;
    if (!keep) begin
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;
      bus.in_amt   = ~a;
      bus.in_op    = ~o;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) fail("drain_timeout");
    #1;
  endtask

  initial begin
    int h0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h11, 3'd2, LSR, 8'h04, 0); drain();
    send(8'hF0, 3'd3, LSL, 8'h80, 0); drain();
    send(8'hCC, 3'd2, LSR, 8'h33, 0); drain();
    send(8'h80, 3'd3, ASR, 8'hF0, 0); drain();
    send(8'hCC, 3'd3, ASR, 8'hF9, 0); drain();
    send(8'h55, 3'd2, ASL, 8'h54, 0); drain();
    send(8'h55, 3'd3, ASR, 8'h0A, 0); drain();
    send(8'h81, 3'd0, LSL, 8'h81, 0); drain();
    send(8'h80, 3'd7, ASR, 8'hFF, 0); drain();
    send(8'h80, 3'd7, LSR, 8'h01, 0); drain();
    send(8'h01, 3'd7, LSL, 8'h80, 0); drain();

    // Backpressure with inputs scrambled while busy.
    bus.out_ready = 1'b0;
    send(8'hCC, 3'd3, ASR, 8'hF9, 0);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    if (!bus.out_valid) fail("bp_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_data", 32'(bus.out_data), 32'hF9);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Back-to-back with in_valid held high.
    b2b = 1; b2b_armed = 0; h0 = hs_cnt;
    send(8'h96, 3'd1, ASR, 8'hCB, 1);
    send(8'h96, 3'd4, LSR, 8'h09, 1);
    send(8'h3C, 3'd0, LSL, 8'h3C, 1);
    send(8'h0F, 3'd5, ASL, 8'hE0, 1);
    bus.in_valid = 1'b0;
    drain();
    b2b = 0;
    check("b2b_results", 32'(hs_cnt - h0), 32'd4);

    // Asynchronous reset in the middle of a shift.
    send(8'hFF, 3'd7, LSL, 8'h80, 0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'h00);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    sb.delete();
    seen = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("post_rst_no_output", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(8'h55, 3'd1, LSR, 8'h2A, 0); drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle shift engine that performs logical and arithmetic left/right shifts on a WIDTH-bit operand, one bit position per clock. It sits directly upstream of the combinational shift-result consumers, replacing single-cycle `>>`, `<<`, `>>>` and `<<<` with an iterative datapath and a valid/ready handshake on both sides. The result matches the Verilog operator on a signed operand of the same width.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- AMTW, 3, shift-amount width; legal amounts 0..2^AMTW−1, with 2^AMTW−1 ≤ WIDTH−1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- in_data  input  WIDTH  operand, treated as two's-complement for arithmetic ops
- in_amt  input  AMTW  shift distance
- in_op  input  2  00 = LSR (`>>`), 01 = LSL (`<<`), 10 = ASR (`>>>`), 11 = ASL (`<<<`, identical to LSL)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- busy  output  1  high in SHIFT or DONE

## Operation
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- FSM states: IDLE, SHIFT, DONE. Registers: shreg[WIDTH], cnt[AMTW], op[2].
- IDLE: in_ready=1. On in_valid&&in_ready, load shreg=in_data, cnt=in_amt, op=in_op.
  - in_amt==0 → DONE.
  - otherwise → SHIFT.
- SHIFT: each edge applies one 1-bit shift and sets cnt=cnt−1. When cnt==1 at the edge, go to DONE.
  - LSR: shreg = {1'b0, shreg[WIDTH-1:1]}
  - ASR: shreg = {shreg[WIDTH-1], shreg[WIDTH-1:1]}
  - LSL/ASL: shreg = {shreg[WIDTH-2:0], 1'b0}
- DONE: out_valid=1, out_data=shreg. Hold until out_ready; on out_valid&&out_ready, go to IDLE.
- in_ready=0 in SHIFT and DONE. No overlap: the unit holds at most one request.
- Inputs in_data, in_amt and in_op are sampled only at the accept edge. Later changes are ignored.
- out_data is stable while out_valid=1 and out_ready=0.
- Reset (any state, including mid-shift or while a result is pending):
  - state=IDLE; shreg, cnt, op=0
  - out_valid=0, out_data=0, busy=0, in_ready=1
  - the in-flight request is discarded with no output.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- Latency from accept edge E0 to out_valid high:
  - amt=0: out_valid high after E0 (1 cycle)
  - amt=N>0: out_valid high after edge E0+N (N+1 cycles)
- Result handshake at edge Ek: out_valid falls and in_ready rises after Ek. The next accept can occur at Ek+1 at the earliest.
- Throughput with out_ready held high: one result per N+2 cycles.
- out_valid, in_ready and busy are decoded from registered state only, with no combinational path from inputs. out_data is a direct register output.

## Test plan
- Logical ops, out_ready=1:
  - LSR 0x11 by 2 → 0x04 after 3 cycles
  - LSL 0xF0 by 3 → 0x80 after 4 cycles
  - LSR 0xCC by 2 → 0x33
- Arithmetic ops:
  - ASR 0x80 by 3 → 0xF0
  - ASR 0xCC by 3 → 0xF9
  - ASL 0x55 by 2 → 0x54
  - ASR 0x55 by 3 → 0x0A
- Boundaries:
  - amt=0 on 0x81 → 0x81 after 1 cycle
  - ASR 0x80 by 7 → 0xFF
  - LSR 0x80 by 7 → 0x01
  - LSL 0x01 by 7 → 0x80
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. out_data stays stable and in_ready stays 0. Change in_data while busy → result is unaffected.
- Back-to-back requests with in_valid held high: each request is accepted exactly one cycle after the prior result handshake, with no dropped or duplicated results.
- Reset mid-operation: assert rst_n=0 asynchronously mid-SHIFT on LSL 0xFF by 7 → outputs reach reset values immediately with no clock. After release, in_ready=1 and a new LSR 0x55 by 1 → 0x2A.
